// File: rtl/floating_point_accum_tlast_gen.sv
// AXI-stream packet framer: passes the operand stream straight through and marks
// the final beat of each packet with m_tlast, using table or fixed lengths.
module floating_point_accum_tlast_gen #(
    parameter int                         DATA_W    = 32,
    parameter int                         CNT_W     = 8,
    parameter int                         NUM_PKTS  = 2,
    parameter logic [NUM_PKTS*CNT_W-1:0]  LEN_TABLE = {8'd2, 8'd8}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic              err_len0
);

    localparam int PKT_W = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam logic [PKT_W-1:0] LAST_PKT = PKT_W'(NUM_PKTS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PKT_W-1:0]   pkt_idx_q, pkt_idx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   cur_len_q, cur_len_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cfg_len_q, cfg_len_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               beat_acc;
    logic               is_last;
    logic [CNT_W-1:0]   raw_len;

    // Unmodified length for packet idx; a zero here is the error case.
    function automatic logic [CNT_W-1:0] len_of(input logic m, input logic [CNT_W-1:0] cfg,
                                                 input logic [PKT_W-1:0] idx);
        logic [CNT_W-1:0] r;
        r = '0;
        if (m) begin
            r = cfg;
        end else begin
            for (int i = 0; i < NUM_PKTS; i++) begin
                if (idx == i[PKT_W-1:0]) r = LEN_TABLE[i*CNT_W +: CNT_W];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pkt_idx_q  <= '0;
            beat_cnt_q <= '0;
            cur_len_q  <= '0;
            mode_q     <= 1'b0;
            cfg_len_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_idx_q  <= pkt_idx_d;
            beat_cnt_q <= beat_cnt_d;
            cur_len_q  <= cur_len_d;
            mode_q     <= mode_d;
            cfg_len_q  <= cfg_len_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign is_last  = (beat_cnt_q == cur_len_q - CNT_W'(1));
    assign beat_acc = (state_q == ST_RUN) && s_tvalid && m_tready;

    always_comb begin
        state_d    = state_q;
        pkt_idx_d  = pkt_idx_q;
        beat_cnt_d = beat_cnt_q;
        cur_len_d  = cur_len_q;
        mode_d     = mode_q;
        cfg_len_d  = cfg_len_q;
        done_d     = 1'b0;
        err_d      = err_q;
        raw_len    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    raw_len    = len_of(mode, cfg_len, '0);
                    mode_d     = mode;
                    cfg_len_d  = cfg_len;
                    pkt_idx_d  = '0;
                    beat_cnt_d = '0;
                    cur_len_d  = (raw_len == '0) ? CNT_W'(1) : raw_len;
                    err_d      = (raw_len == '0);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort outranks everything, including a coincident last beat
                if (abort) begin
                    state_d    = ST_IDLE;
                    pkt_idx_d  = '0;
                    beat_cnt_d = '0;
                    cur_len_d  = '0;
                end else if (beat_acc) begin
                    if (is_last) begin
                        beat_cnt_d = '0;
                        if (pkt_idx_q != LAST_PKT) begin
                            raw_len   = len_of(mode_q, cfg_len_q, pkt_idx_q + PKT_W'(1));
                            pkt_idx_d = pkt_idx_q + PKT_W'(1);
                            cur_len_d = (raw_len == '0) ? CNT_W'(1) : raw_len;
                            err_d     = err_q | (raw_len == '0);
                        end else if (loop_en) begin
                            raw_len   = len_of(mode_q, cfg_len_q, '0);
                            pkt_idx_d = '0;
                            cur_len_d = (raw_len == '0) ? CNT_W'(1) : raw_len;
                            err_d     = err_q | (raw_len == '0);
                        end else begin
                            state_d   = ST_IDLE;
                            pkt_idx_d = '0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake: zero-latency passthrough in RUN (m_tvalid=s_tvalid, s_tready=m_tready);
    // a beat moves when m_tvalid & m_tready; both sides are held off in IDLE.
    always_comb begin
        m_tdata  = s_tdata;
        m_tvalid = 1'b0;
        s_tready = 1'b0;
        m_tlast  = 1'b0;
        if (state_q == ST_RUN) begin
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            m_tlast  = is_last;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign err_len0 = err_q;

endmodule

// File: tb/tb_floating_point_accum_tlast_gen.sv
// Bench for floating_point_accum_tlast_gen: a per-cycle vector table for the basic
// sequence plus randomized sequences checked against a per-beat tlast queue model.
module tb_floating_point_accum_tlast_gen;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int NUM_PKTS = 2;
    localparam logic [NUM_PKTS*CNT_W-1:0] LEN_TABLE = {8'd2, 8'd8};
    localparam int BUDGET = 400;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, mode, loop_en;
    logic [CNT_W-1:0]  cfg_len;
    logic [DATA_W-1:0] s_tdata, m_tdata;
    logic              s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic              busy, done, err_len0;

    int n_checks = 0;
    int n_err = 0;

    // Expected per-beat markers: 0 = plain beat, 1 = packet end, 2 = sequence end.
    int tl_q[$];

    typedef struct {
        bit start;
        bit vld;
        bit rdy;
        bit e_busy;
        bit e_tlast;
        bit e_done;
        bit e_sready;
    } vec_t;

    vec_t vecs[13];

    floating_point_accum_tlast_gen #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_PKTS(NUM_PKTS), .LEN_TABLE(LEN_TABLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .cfg_len(cfg_len), .loop_en(loop_en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .done(done), .err_len0(err_len0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit st, bit v, bit r, bit eb, bit et, bit ed, bit es);
        vec_t x;
        x.start = st; x.vld = v; x.rdy = r;
        x.e_busy = eb; x.e_tlast = et; x.e_done = ed; x.e_sready = es;
        return x;
    endfunction

    // Expand one whole sequence into per-beat markers.
    task automatic fill(input bit m, input logic [CNT_W-1:0] len);
        logic [NUM_PKTS*CNT_W-1:0] tab;
        int l;
        tab = LEN_TABLE;
        for (int i = 0; i < NUM_PKTS; i++) begin
            l = m ? int'(len) : int'(tab[i*CNT_W +: CNT_W]);
            if (l == 0) l = 1;
            for (int b = 0; b < l; b++)
                tl_q.push_back((b != l - 1) ? 0 : ((i == NUM_PKTS - 1) ? 2 : 1));
        end
    endtask

    task automatic run_seq(input string tag, input bit m, input logic [CNT_W-1:0] len,
                           input bit loop, input int drop_loop_at, input bit gaps,
                           input int abort_at, input int start_at, input int exp_beats);
        int beat_no = 0;
        int cyc = 0;
        int tail = 3;
        int front;
        bit m_busy, m_done, m_err, acc, ab, lp;
        @(posedge clk); #1;
        start = 1'b1; mode = m; cfg_len = len; loop_en = loop;
        s_tvalid = 1'b0; m_tready = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk({tag, "_start_busy"}, busy, 0);
        tl_q.delete();
        fill(m, len);
        m_busy = 1; m_done = 0; m_err = (m && len == 0);
        while (tail > 0 && cyc < BUDGET) begin
            @(posedge clk); #1;
            start    = m_busy && (beat_no == start_at);
            mode     = 1'($urandom);
            cfg_len  = CNT_W'($urandom);
            lp       = loop && (beat_no < drop_loop_at);
            loop_en  = lp;
            s_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata  = $urandom;
            ab       = m_busy && (beat_no == abort_at);
            abort    = ab;
            @(negedge clk);
            chk({tag, "_busy"}, busy, m_busy);
            chk({tag, "_done"}, done, m_done);
            chk({tag, "_err_len0"}, err_len0, m_err);
            if (m_busy) begin
                chk({tag, "_tlast"}, m_tlast, tl_q[0] != 0);
                chk({tag, "_s_tready"}, s_tready, m_tready);
                chk({tag, "_m_tvalid"}, m_tvalid, s_tvalid);
                if (s_tvalid) chk({tag, "_m_tdata"}, m_tdata, s_tdata);
            end else begin
                chk({tag, "_idle_s_tready"}, s_tready, 0);
                chk({tag, "_idle_m_tvalid"}, m_tvalid, 0);
                chk({tag, "_idle_tlast"}, m_tlast, 0);
            end
            m_done = 0;
            acc = m_busy && s_tvalid && m_tready;
            if (ab) begin
                m_busy = 0;
            end else if (acc) begin
                front = tl_q.pop_front();
                beat_no++;
                if (front == 2) begin
                    if (lp) fill(m, len);
                    else begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
            if (!m_busy) tail--;
            cyc++;
        end
        chk({tag, "_beats"}, beat_no, exp_beats);
        chk({tag, "_timeout"}, (cyc >= BUDGET), 0);
        start = 1'b0; abort = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; loop_en = 1'b0;
        cfg_len = '0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;

        vecs[0] = mk(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) vecs[i] = mk(0, 1, 1, 1, 0, 0, 1);
        vecs[8]  = mk(0, 1, 1, 1, 1, 0, 1);
        vecs[10] = mk(0, 1, 1, 1, 1, 0, 1);
        vecs[11] = mk(0, 1, 1, 0, 0, 1, 0);
        vecs[12] = mk(0, 1, 1, 0, 0, 0, 0);

        #13;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_len0, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            start = vecs[i].start; s_tvalid = vecs[i].vld; m_tready = vecs[i].rdy;
            s_tdata = $urandom;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_tlast", i), m_tlast, vecs[i].e_tlast);
            chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            chk($sformatf("vec%0d_s_tready", i), s_tready, vecs[i].e_sready);
            chk($sformatf("vec%0d_m_tvalid", i), m_tvalid, vecs[i].vld && vecs[i].e_busy);
        end
        start = 1'b0;

        run_seq("gaps", 0, 8'd0, 0, 0, 1, -1, 3, 10);
        run_seq("gaps2", 0, 8'd0, 0, 0, 1, -1, 6, 10);
        run_seq("start_on_last", 0, 8'd0, 0, 0, 0, -1, 9, 10);
        run_seq("loop3", 1, 8'd3, 1, 10, 1, -1, -1, 12);
        run_seq("len0", 1, 8'd0, 0, 0, 1, -1, -1, 2);
        run_seq("abort", 0, 8'd0, 0, 0, 0, 4, -1, 4);
        run_seq("after_abort", 0, 8'd0, 0, 0, 1, -1, -1, 10);
        run_seq("fix5", 1, 8'd5, 0, 0, 1, -1, 2, 10);

        // Asynchronous reset mid-packet, with tlast and err_len0 both high beforehand.
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; cfg_len = 8'd0; loop_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("prerst_busy", busy, 1);
        chk("prerst_tlast", m_tlast, 1);
        chk("prerst_err", err_len0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_tlast", m_tlast, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_err", err_len0, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0; loop_en = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/floating_point_accum_tlast_gen.md
Name: floating_point_accum_tlast_gen

Overview:
- Parametrised AXI-stream packet framer for the floating-point accumulator onboard test path.
- Passes an operand stream from source to accumulator and generates m_tlast on the final beat of each packet.
- Packet lengths come either from a parameter length table or from a runtime fixed length.
- Supports multi-packet sequences, looping, abort and a completion pulse; replaces the fixed 10-entry tlast ROM approach.

Parameters:
DATA_W, 32, stream data width.
CNT_W, 8, beat-counter/length width; max packet length 2^CNT_W-1.
NUM_PKTS, 2, packets per sequence; must be >= 1.
LEN_TABLE, {8'd2,8'd8}, packed NUM_PKTS*CNT_W lengths; entry i at bits [i*CNT_W +: CNT_W] (default: pkt0=8 beats, pkt1=2 beats).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse, begins a sequence when idle.
abort  in  1  one-cycle pulse, terminates sequence immediately.
mode  in  1  0 = table lengths, 1 = fixed length cfg_len for every packet; sampled on start.
cfg_len  in  CNT_W  fixed packet length; sampled on start.
loop_en  in  1  1 = restart at pkt0 after the last packet; sampled live at each sequence end.
s_tdata  in  DATA_W  source data.
s_tvalid  in  1  source valid.
s_tready  out  1  source ready.
m_tdata  out  DATA_W  sink data.
m_tvalid  out  1  sink valid.
m_tready  in  1  sink ready.
m_tlast  out  1  last beat of current packet.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when a non-looping sequence completes.
err_len0  out  1  sticky: a zero length was encountered; cleared only by reset or start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pkt_idx=0, beat_cnt=0, cur_len=0, done=0, err_len0=0, busy=0.
- States: IDLE, RUN.
- IDLE:
  - s_tready=0, m_tvalid=0, m_tlast=0.
  - m_tdata=s_tdata (don't-care).
  - On start: latch mode/cfg_len, pkt_idx=0, beat_cnt=0, cur_len=len(0), clear err_len0, go RUN.
- len(i):
  - mode=0: LEN_TABLE entry i; mode=1: latched cfg_len.
  - A length of 0 is treated as 1 and sets err_len0.
- RUN (combinational passthrough, zero latency):
  - m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
  - m_tlast=(beat_cnt==cur_len-1); valid whenever m_tvalid.
- Beat accepted = m_tvalid & m_tready. Counters advance only on an accepted beat; stalls hold all state and m_tlast stable.
- Non-last accepted beat: beat_cnt++.
- Last accepted beat (m_tlast=1):
  - beat_cnt=0.
  - If pkt_idx<NUM_PKTS-1: pkt_idx++, cur_len=len(pkt_idx+1).
  - Else if loop_en=1: pkt_idx=0, cur_len=len(0), stay RUN, no done.
  - Else: go IDLE, done=1 next cycle for exactly one cycle.
- start while RUN is ignored.
- start coincident with the final beat is ignored; IDLE is entered that cycle.
- abort in RUN: next cycle IDLE, counters cleared, no done. The beat accepted in the abort cycle is passed but not counted. abort in IDLE has no effect.
- abort and a last beat in the same cycle: abort wins; no done.
- busy=(state==RUN).
- Reset mid-packet drops to IDLE asynchronously; the partial packet is never terminated with tlast.

Test Plan:
- Default params, mode=0, start, 10 beats, m_tready=1 -> m_tlast on beats 7 and 9 (0-based); done pulses one cycle after beat 9; busy low after.
- Same with random s_tvalid/m_tready gaps -> identical tlast beat positions; m_tlast and counters frozen during stalls; no beat lost or duplicated.
- mode=1, cfg_len=3, loop_en=1, 12 beats -> m_tlast on beats 2,5,8,11; no done; drop loop_en before beat 11 -> done after beat 11.
- mode=1, cfg_len=0 -> every beat has m_tlast=1; err_len0=1 until next start.
- abort at beat 4 of pkt0 -> IDLE next cycle, s_tready=0, no done. New start -> tlast again at beat 7.
- rst_n low mid-packet (beat 5) -> all outputs at reset values immediately. start pulsed during RUN -> no restart, sequence positions unchanged.
